// File: rtl/b16_uart.sv
// b16_uart: memory-mapped 8N1 UART for the b16 top-level I/O window.
// DATA register (addr1=0) feeds a TX FIFO and drains an RX FIFO; STATUS
// register (addr1=1) reports flags and holds the TX-idle interrupt enable.

// Small byte FIFO shared by the transmit and receive paths.
module b16_uart_fifo #(
    parameter int AW = 2
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] din_i,
    output logic [7:0] head_o,
    output logic       empty_o,
    output logic       full_o
);
    localparam int            DEPTH    = 1 << AW;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign do_pop  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot that the push lands in.
    assign do_push = push_i & (~full_o | do_pop);
    assign head_o  = mem_q[rd_ptr_q];

    // Byte storage.
    // NOTE: the storage array is deliberately not reset; the pointers and
    // count decide which entries are valid, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

module b16_uart #(
    parameter int CLK_HZ  = 50000000,
    parameter int BAUD    = 115200,
    parameter int FIFO_AW = 2
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        sel,
    input  logic        addr1,
    input  logic        r,
    input  logic [1:0]  w,
    input  logic [15:0] dwrite,
    output logic [15:0] dout,
    input  logic        rxd,
    output logic        txd,
    output logic        irq
);
    localparam int DIV_RAW = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int DIV     = (DIV_RAW < 4) ? 4 : DIV_RAW;
    localparam int CW      = $clog2(DIV);
    localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    // ---------------- bus decode ----------------
    logic data_wr;
    logic data_rd;
    logic stat_wr;
    assign data_wr = sel & ~addr1 & w[0];
    assign data_rd = sel & ~addr1 & r;
    assign stat_wr = sel &  addr1 & w[0];

    // The high byte lane carries nothing this peripheral stores.
    logic unused_bits;
    assign unused_bits = ^{w[1], dwrite[15:8]};

    // ---------------- TX path ----------------
    logic          tx_pop;
    logic [7:0]    tx_head;
    logic          tx_empty;
    logic          tx_full;
    state_e        tx_state_q;
    logic [CW-1:0] tx_cnt_q;
    logic [2:0]    tx_bit_q;
    logic [7:0]    tx_shift_q;
    logic          txd_q;
    logic          tx_bit_end;
    logic          tx_idle;

    b16_uart_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk     (clk),
        .nreset  (nreset),
        .push_i  (data_wr),
        .pop_i   (tx_pop),
        .din_i   (dwrite[7:0]),
        .head_o  (tx_head),
        .empty_o (tx_empty),
        .full_o  (tx_full)
    );

    assign tx_bit_end = (tx_cnt_q == BIT_END);
    // Head leaves the FIFO when a frame starts: from IDLE, or straight out of
    // a finishing STOP so consecutive frames have no idle gap.
    assign tx_pop  = ~tx_empty & ((tx_state_q == S_IDLE) |
                                  ((tx_state_q == S_STOP) & tx_bit_end));
    assign tx_idle = (tx_state_q == S_IDLE) & tx_empty;
    assign txd     = txd_q;

    // Transmit sequencer; txd is registered from the state, one clock behind.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
        end else begin
            case (tx_state_q)
                S_START: txd_q <= 1'b0;
                S_DATA:  txd_q <= tx_shift_q[0];
                default: txd_q <= 1'b1;
            endcase

            case (tx_state_q)
                S_IDLE: begin
                    if (tx_pop) begin
                        tx_state_q <= S_START;
                        tx_cnt_q   <= '0;
                        tx_shift_q <= tx_head;
                    end
                end
                S_START: begin
                    if (tx_bit_end) begin
                        tx_state_q <= S_DATA;
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt_q   <= '0;
                        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        if (tx_bit_q == 3'd7) begin
                            tx_state_q <= S_STOP;
                        end else begin
                            tx_bit_q <= tx_bit_q + 1'b1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (tx_bit_end) begin
                        tx_cnt_q <= '0;
                        if (tx_pop) begin
                            tx_state_q <= S_START;
                            tx_shift_q <= tx_head;
                        end else begin
                            tx_state_q <= S_IDLE;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_state_q <= S_IDLE;
            endcase
        end
    end

    // ---------------- RX path ----------------
    logic [1:0]    rx_sync_q;
    logic          rx_prev_q;
    logic          rx_s;
    state_e        rx_state_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_shift_q;
    logic          rx_bit_end;
    logic          rx_stop_smp;
    logic          rx_push;
    logic          rx_pop;
    logic [7:0]    rx_head;
    logic          rx_empty;
    logic          rx_full;
    logic          rx_valid;
    logic          ovr_evt;
    logic          fe_evt;

    assign rx_s        = rx_sync_q[1];
    assign rx_bit_end  = (rx_cnt_q == BIT_END);
    assign rx_stop_smp = (rx_state_q == S_STOP) & rx_bit_end;
    assign rx_push     = rx_stop_smp & rx_s;
    assign rx_pop      = data_rd & ~rx_empty;
    assign rx_valid    = ~rx_empty;
    // A coinciding CPU pop makes room, so a full FIFO is not an overrun then.
    assign ovr_evt     = rx_push & rx_full & ~rx_pop;
    assign fe_evt      = rx_stop_smp & ~rx_s;

    b16_uart_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk     (clk),
        .nreset  (nreset),
        .push_i  (rx_push),
        .pop_i   (rx_pop),
        .din_i   (rx_shift_q),
        .head_o  (rx_head),
        .empty_o (rx_empty),
        .full_o  (rx_full)
    );

    // Two-flop synchronizer for the asynchronous line plus an edge history bit.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rx_sync_q <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            rx_sync_q <= {rx_sync_q[0], rxd};
            rx_prev_q <= rx_s;
        end
    end

    // Receive sequencer: mid-bit sampling, glitch reject on the start bit.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            case (rx_state_q)
                S_IDLE: begin
                    if (rx_prev_q & ~rx_s) begin
                        rx_state_q <= S_START;
                        rx_cnt_q   <= '0;
                    end
                end
                S_START: begin
                    if (rx_cnt_q == HALF_END) begin
                        rx_cnt_q <= '0;
                        if (rx_s) begin
                            rx_state_q <= S_IDLE;
                        end else begin
                            rx_state_q <= S_DATA;
                            rx_bit_q   <= '0;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_bit_end) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_s, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= S_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (rx_bit_end) begin
                        rx_state_q <= S_IDLE;
                        rx_cnt_q   <= '0;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= S_IDLE;
            endcase
        end
    end

    // ---------------- status, interrupt, read mux ----------------
    logic overrun_q;
    logic frame_err_q;
    logic ie_tx_q;
    logic irq_q;

    assign irq = irq_q;

    // Sticky error flags, interrupt enable and registered interrupt.
    // A hardware event in the same cycle as a software clear wins.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            ie_tx_q     <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            if (stat_wr) begin
                if (dwrite[3]) overrun_q   <= 1'b0;
                if (dwrite[4]) frame_err_q <= 1'b0;
                ie_tx_q <= dwrite[5];
            end
            if (ovr_evt) overrun_q   <= 1'b1;
            if (fe_evt)  frame_err_q <= 1'b1;
            irq_q <= rx_valid | (tx_idle & ie_tx_q);
        end
    end

    // Combinational read data from registered state.
    // NOTE: dout gets a default first so no path leaves it unassigned and
    // no latch is inferred.
    always_comb begin
        dout = 16'h0000;
        if (sel & r) begin
            if (addr1) begin
                dout = {10'b0, ie_tx_q, frame_err_q, overrun_q,
                        tx_idle, ~tx_full, rx_valid};
            end else if (rx_valid) begin
                dout = {8'h00, rx_head};
            end
        end
    end
endmodule

// File: tb/tb_b16_uart.sv
// Self-checking bench for b16_uart at DIV = 16 clocks per bit.
module tb_b16_uart;
    logic        clk = 1'b0;
    logic        nreset;
    logic        sel;
    logic        addr1;
    logic        r;
    logic [1:0]  w;
    logic [15:0] dwrite;
    logic [15:0] dout;
    logic        rxd;
    logic        txd;
    logic        irq;

    int checks = 0;
    int errors = 0;

    b16_uart #(.CLK_HZ(1600000), .BAUD(100000), .FIFO_AW(2)) dut (
        .clk    (clk),
        .nreset (nreset),
        .sel    (sel),
        .addr1  (addr1),
        .r      (r),
        .w      (w),
        .dwrite (dwrite),
        .dout   (dout),
        .rxd    (rxd),
        .txd    (txd),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        bit          rd;
        bit          s;
        bit          a1;
        logic [1:0]  wl;
        logic [15:0] wd;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic s, input logic a1, input logic [1:0] wl, input logic [15:0] d);
        @(negedge clk);
        sel = s; addr1 = a1; w = wl; dwrite = d;
        @(posedge clk);
        #1;
        sel = 1'b0; w = 2'b00; dwrite = 16'h0000;
    endtask

    task automatic cpu_read(input logic s, input logic a1, output logic [15:0] d);
        @(negedge clk);
        sel = s; addr1 = a1; r = 1'b1;
        #1 d = dout;
        @(posedge clk);
        #1;
        sel = 1'b0; r = 1'b0;
    endtask

    // Drive one 8N1 frame on rxd with a selectable stop-bit level.
    task automatic send_rx(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        wait_cyc(16);
        for (int k = 0; k < 8; k++) begin
            rxd = b[k];
            wait_cyc(16);
        end
        rxd = stop;
        wait_cyc(16);
        rxd = 1'b1;
    endtask

    // Watch txd for a start bit within budget clocks, then decode the frame.
    task automatic line_rx(input int budget, output logic [7:0] b, output bit ok);
        ok = 1'b0;
        b  = 8'h00;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (txd == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            wait_cyc(8);
            if (txd !== 1'b0) ok = 1'b0;
            for (int k = 0; k < 8; k++) begin
                wait_cyc(16);
                b[k] = txd;
            end
            wait_cyc(16);
            if (txd !== 1'b1) ok = 1'b0;
        end
    endtask

    initial begin
        logic [15:0] rd;
        logic [7:0]  lb;
        bit          ok;
        logic [7:0]  exp_bits;

        nreset = 1'b0; sel = 1'b0; addr1 = 1'b0; r = 1'b0;
        w = 2'b00; dwrite = 16'h0000; rxd = 1'b1;

        // ---------- reset ----------
        wait_cyc(3);
        check("rst_txd_in_reset", {15'b0, txd}, 16'h0001);
        @(negedge clk);
        nreset = 1'b1;
        wait_cyc(2);
        check("rst_txd", {15'b0, txd}, 16'h0001);
        check("rst_irq", {15'b0, irq}, 16'h0000);

        // ---------- register access table ----------
        vecs[0]  = '{1, 1, 1, 2'b00, 16'h0000, 16'h0006}; // STATUS after reset
        vecs[1]  = '{1, 1, 0, 2'b00, 16'h0000, 16'h0000}; // empty DATA read
        vecs[2]  = '{0, 1, 1, 2'b01, 16'h0020, 16'h0000}; // ie_tx = 1
        vecs[3]  = '{1, 1, 1, 2'b00, 16'h0000, 16'h0026};
        vecs[4]  = '{0, 1, 1, 2'b10, 16'h0000, 16'h0000}; // high lane only: ignored
        vecs[5]  = '{1, 1, 1, 2'b00, 16'h0000, 16'h0026};
        vecs[6]  = '{0, 1, 1, 2'b01, 16'h00C7, 16'h0000}; // ie_tx = 0, other bits ignored
        vecs[7]  = '{1, 1, 1, 2'b00, 16'h0000, 16'h0006};
        vecs[8]  = '{0, 1, 0, 2'b10, 16'h55AA, 16'h0000}; // w[1] alone: no push
        vecs[9]  = '{1, 1, 1, 2'b00, 16'h0000, 16'h0006};
        vecs[10] = '{1, 0, 1, 2'b00, 16'h0000, 16'h0000}; // not selected: dout 0
        vecs[11] = '{0, 0, 0, 2'b01, 16'h0077, 16'h0000}; // not selected: no push
        vecs[12] = '{1, 1, 1, 2'b00, 16'h0000, 16'h0006};
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].rd) begin
                cpu_read(vecs[i].s, vecs[i].a1, rd);
                check($sformatf("vec%0d", i), rd, vecs[i].exp);
            end else begin
                cpu_write(vecs[i].s, vecs[i].a1, vecs[i].wl, vecs[i].wd);
            end
        end

        // ---------- irq latency on ie_tx ----------
        cpu_write(1, 1, 2'b01, 16'h0020);
        check("irq_lat_0", {15'b0, irq}, 16'h0000);
        wait_cyc(1);
        check("irq_lat_1", {15'b0, irq}, 16'h0001);
        cpu_write(1, 1, 2'b01, 16'h0000);
        wait_cyc(1);
        check("irq_off", {15'b0, irq}, 16'h0000);

        // ---------- single TX: 0x55 ----------
        cpu_write(1, 0, 2'b11, 16'h1255);
        wait_cyc(1);
        check("tx_lat_e1", {15'b0, txd}, 16'h0001);
        wait_cyc(1);
        check("tx_lat_e2", {15'b0, txd}, 16'h0000);
        wait_cyc(8);
        check("tx_start_mid", {15'b0, txd}, 16'h0000);
        exp_bits = 8'h55;
        for (int k = 0; k < 8; k++) begin
            wait_cyc(16);
            check($sformatf("tx_bit%0d", k), {15'b0, txd}, {15'b0, exp_bits[k]});
        end
        wait_cyc(16);
        check("tx_stop", {15'b0, txd}, 16'h0001);
        cpu_read(1, 1, rd);
        check("tx_busy_status", rd, 16'h0002);
        wait_cyc(10);
        cpu_read(1, 1, rd);
        check("tx_idle_status", rd, 16'h0006);

        // ---------- TX full, back-to-back frames ----------
        fork
            begin
                for (int f = 0; f < 5; f++) begin
                    line_rx((f == 0) ? 20 : 12, lb, ok);
                    check($sformatf("txq_frame%0d_ok", f), {15'b0, ok}, 16'h0001);
                    check($sformatf("txq_frame%0d_byte", f), {8'h00, lb}, 16'(f + 1));
                end
            end
            begin
                for (int i = 1; i <= 5; i++) begin
                    cpu_write(1, 0, 2'b01, 16'(i));
                end
                cpu_read(1, 1, rd);
                check("txq_full_status", rd, 16'h0000);
                cpu_write(1, 0, 2'b01, 16'h0006);
            end
        join
        line_rx(40, lb, ok);
        check("txq_6th_dropped", {15'b0, ok}, 16'h0000);
        cpu_read(1, 1, rd);
        check("txq_idle_status", rd, 16'h0006);

        // ---------- RX single byte ----------
        send_rx(8'hA5, 1'b1);
        cpu_read(1, 1, rd);
        check("rx_status", rd, 16'h0007);
        check("rx_irq", {15'b0, irq}, 16'h0001);
        cpu_read(1, 0, rd);
        check("rx_data", rd, 16'h00A5);
        cpu_read(1, 1, rd);
        check("rx_popped_status", rd, 16'h0006);
        check("rx_irq_clear", {15'b0, irq}, 16'h0000);

        // ---------- RX overrun ----------
        for (int i = 1; i <= 5; i++) begin
            send_rx(8'(i * 8'h11), 1'b1);
        end
        cpu_read(1, 1, rd);
        check("ovr_status", rd, 16'h000F);
        for (int i = 1; i <= 4; i++) begin
            cpu_read(1, 0, rd);
            check($sformatf("ovr_data%0d", i), rd, 16'(i * 16'h11));
        end
        cpu_read(1, 0, rd);
        check("ovr_empty_data", rd, 16'h0000);
        cpu_read(1, 1, rd);
        check("ovr_sticky", rd, 16'h000E);

        // ---------- RX framing error ----------
        send_rx(8'h3C, 1'b0);
        wait_cyc(20);
        cpu_read(1, 1, rd);
        check("fe_status", rd, 16'h001E);
        cpu_read(1, 0, rd);
        check("fe_no_push", rd, 16'h0000);
        cpu_write(1, 1, 2'b01, 16'h0018);
        cpu_read(1, 1, rd);
        check("err_cleared", rd, 16'h0006);

        // ---------- RX glitch ----------
        rxd = 1'b0;
        wait_cyc(4);
        rxd = 1'b1;
        wait_cyc(200);
        cpu_read(1, 1, rd);
        check("glitch_status", rd, 16'h0006);

        // ---------- reset mid TX frame ----------
        cpu_write(1, 0, 2'b01, 16'h0000);
        wait_cyc(40);
        check("rst_mid_low", {15'b0, txd}, 16'h0000);
        #2 nreset = 1'b0;
        #1;
        check("rst_mid_txd", {15'b0, txd}, 16'h0001);
        wait_cyc(3);
        @(negedge clk);
        nreset = 1'b1;
        wait_cyc(2);
        cpu_read(1, 1, rd);
        check("rst_mid_status", rd, 16'h0006);
        wait_cyc(40);
        check("rst_mid_line_idle", {15'b0, txd}, 16'h0001);
        check("rst_mid_irq", {15'b0, irq}, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
